bfm_memory_wb_slave: RTL and testbench



---
 rtl/peripheral_wb_pkg.sv | 19 +
 rtl/peripheral_wb_next_adr.sv | 27 ++
 rtl/bfm_memory_wb_slave.sv | 131 +++++++++++++
 tb/tb_bfm_memory_wb_slave.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_wb_pkg.sv
// Wishbone B3 cycle/burst type constants shared by the BFM memory
// slave and its burst address helper.
package peripheral_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } wb_state_e;

endpackage

// File: rtl/peripheral_wb_next_adr.sv
// Next beat address for a Wishbone incrementing burst; wrapping
// bursts keep the upper bits and wrap inside an aligned window.
module peripheral_wb_next_adr
   import peripheral_wb_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] adr,
   input  logic [1:0]    bte,
   output logic [AW-1:0] next_adr
);

   logic [AW-1:0] inc;

   assign inc = adr + AW'(4);

   always_comb begin
      next_adr = inc;
      unique case (bte)
         BTE_WRAP4:  next_adr = {adr[AW-1:4], inc[3:0]};
         BTE_WRAP8:  next_adr = {adr[AW-1:5], inc[4:0]};
         BTE_WRAP16: next_adr = {adr[AW-1:6], inc[5:0]};
         default:    next_adr = inc;
      endcase
   end

endmodule

// File: rtl/bfm_memory_wb_slave.sv
// Wishbone B3 slave memory for the peripheral BFM bench: classic
// cycles, CTI/BTE bursts, byte-lane writes and error responses.
module bfm_memory_wb_slave
   import peripheral_wb_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int MEM_SIZE_BYTES = 32768,
   parameter int DEBUG          = 0
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o
);

   localparam int AB    = $clog2(MEM_SIZE_BYTES);
   localparam int WORDS = MEM_SIZE_BYTES / 4;

   logic [DW-1:0] mem [WORDS] = '{default: '0};

   wb_state_e     state;
   wb_state_e     state_nxt;
   logic          req;
   logic          load;
   logic          resp_ok;
   logic          mem_we;
   logic          ack_nxt;
   logic          err_nxt;
   logic [DW-1:0] dat_nxt;
   logic [AW-1:0] next_adr;
   logic [AW-1:0] resp_adr;

   function automatic logic legal(input logic [AW-1:0] a);
      return (a < AW'(MEM_SIZE_BYTES)) && (a[1:0] == 2'b00);
   endfunction

   assign req      = wb_cyc_i & wb_stb_i;
   assign wb_rty_o = 1'b0;

   peripheral_wb_next_adr #(
      .AW(AW)
   ) u_next_adr (
      .adr      (wb_adr_i),
      .bte      (wb_bte_i),
      .next_adr (next_adr)
   );

   // The response for the coming beat is decided one edge ahead so
   // that ack/err/dat leave the block straight from flops.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      mem_we    = 1'b0;
      resp_adr  = wb_adr_i;
      unique case (state)
         ST_IDLE: begin
            if (req) begin
               state_nxt = ST_ACTIVE;
               load      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!req) begin
               state_nxt = ST_IDLE;
            end else begin
               mem_we = wb_ack_o & wb_we_i
                      & legal(wb_adr_i) & ~wb_rst_i;
               if (wb_cti_i == CTI_INC) begin
                  resp_adr = next_adr;
                  load     = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      resp_ok = legal(resp_adr);
      ack_nxt = 1'b0;
      err_nxt = 1'b0;
      dat_nxt = wb_dat_o;
      if (load) begin
         ack_nxt = resp_ok;
         err_nxt = ~resp_ok;
         dat_nxt = resp_ok ? mem[resp_adr[AB-1:2]] : '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         state    <= state_nxt;
         wb_ack_o <= ack_nxt;
         wb_err_o <= err_nxt;
         wb_dat_o <= dat_nxt;
      end
   end

   // Storage has no reset: contents survive wb_rst_i.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wb_sel_i[i]) begin
               mem[wb_adr_i[AB-1:2]][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
         end
      end
   end

   if (DEBUG != 0) begin : g_debug
   end

endmodule

// File: tb/tb_bfm_memory_wb_slave.sv
// Scoreboard bench for bfm_memory_wb_slave: classic, byte lanes,
// bursts, wrap, illegal access and reset during a burst.
module tb_bfm_memory_wb_slave;
   import peripheral_wb_pkg::*;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_rty_o;

   typedef struct packed {
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   logic rty_seen = 1'b0;

   bfm_memory_wb_slave dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_sel_i (wb_sel_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .wb_rty_o (wb_rty_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(negedge wb_clk_i)
      if (wb_rty_o !== 1'b0) rty_seen = 1'b1;

   task automatic drv(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w,
                      input logic [2:0] c, input logic [1:0] b);
      wb_adr_i = a;
      wb_dat_i = d;
      wb_sel_i = s;
      wb_we_i  = w;
      wb_cti_i = c;
      wb_bte_i = b;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   // Request stays up through the cycle after completion, so "after"
   // shows whether the response dropped while the request persisted.
   task automatic bus_classic(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic w,
                              output logic ack, output logic err,
                              output logic [31:0] rd, output int lat,
                              output logic after);
      drv(a, d, s, w, CTI_CLASSIC, BTE_LINEAR);
      lat = 0;
      while (lat < 8) begin
         @(posedge wb_clk_i);
         lat++;
         #1;
         if (wb_ack_o || wb_err_o) break;
      end
      ack = wb_ack_o;
      err = wb_err_o;
      rd  = wb_dat_o;
      @(posedge wb_clk_i);
      #1;
      after = wb_ack_o | wb_err_o;
      idle_bus();
   endtask

   task automatic bus_burst(input int n, input logic [31:0] a[16],
                            input logic [31:0] d[16], input logic w,
                            input logic [1:0] b,
                            output logic [15:0] acks,
                            output logic [15:0] errs,
                            output logic [31:0] rd[16],
                            output int lat, output logic after);
      acks = '0;
      errs = '0;
      lat  = 0;
      drv(a[0], d[0], 4'hf, w, (n == 1) ? CTI_EOB : CTI_INC, b);
      while (lat < 8) begin
         @(posedge wb_clk_i);
         lat++;
         #1;
         if (wb_ack_o || wb_err_o) break;
      end
      acks[0] = wb_ack_o;
      errs[0] = wb_err_o;
      rd[0]   = wb_dat_o;
      for (int k = 1; k < n; k++) begin
         @(posedge wb_clk_i);
         #1;
         acks[k] = wb_ack_o;
         errs[k] = wb_err_o;
         rd[k]   = wb_dat_o;
         drv(a[k], d[k], 4'hf, w,
             (k == n - 1) ? CTI_EOB : CTI_INC, b);
      end
      @(posedge wb_clk_i);
      #1;
      after = wb_ack_o | wb_err_o;
      idle_bus();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge wb_clk_i);
      #1;
      total++;
      if ({wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o} !== 35'd0) begin
         bad++;
         $display("FAIL reset: ack=%b err=%b rty=%b dat=%h, want 0",
                  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o);
      end
      wb_rst_i = 1'b0;
   endtask

   task automatic test_classic();
      logic        ack, err, after;
      logic [31:0] rd;
      int          lat;
      exp_t        e;
      sbq.push_back('{err: 1'b0, chk: 1'b0, dat: 32'h0});
      bus_classic(32'h100, 32'hDEADBEEF, 4'hf, 1'b1,
                  ack, err, rd, lat, after);
      e = sbq.pop_front();
      total++;
      if (ack !== ~e.err || err !== e.err || lat != 1 || after !== 1'b0)
      begin
         bad++;
         $display("FAIL classic_wr: ack=%b err=%b lat=%0d after=%b, want ack=1 lat=1 after=0",
                  ack, err, lat, after);
      end
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hDEADBEEF});
      bus_classic(32'h100, 32'h0, 4'h0, 1'b0,
                  ack, err, rd, lat, after);
      e = sbq.pop_front();
      total++;
      if (ack !== 1'b1 || err !== 1'b0 || rd !== e.dat || lat != 1
          || after !== 1'b0) begin
         bad++;
         $display("FAIL classic_rd: ack=%b dat=%h lat=%0d after=%b, want ack=1 dat=%h lat=1 after=0",
                  ack, rd, lat, after, e.dat);
      end
   endtask

   task automatic test_byte_lanes();
      logic        ack, err, after;
      logic [31:0] rd;
      int          lat;
      exp_t        e;
      bus_classic(32'h100, 32'h11223344, 4'b0101, 1'b1,
                  ack, err, rd, lat, after);
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hDE22BE44});
      bus_classic(32'h100, 32'h0, 4'b0000, 1'b0,
                  ack, err, rd, lat, after);
      e = sbq.pop_front();
      total++;
      if (ack !== 1'b1 || rd !== e.dat) begin
         bad++;
         $display("FAIL byte_lanes: ack=%b dat=%h, want ack=1 dat=%h",
                  ack, rd, e.dat);
      end
   endtask

   task automatic test_bursts();
      logic [31:0] a[16], d[16], rd[16];
      logic [15:0] acks, errs;
      logic        after;
      int          lat;
      exp_t        e;
      logic [31:0] wrap4[4];
      logic [31:0] wrap8[8];
      wrap4 = '{32'h208, 32'h20C, 32'h200, 32'h204};
      wrap8 = '{32'h218, 32'h21C, 32'h200, 32'h204,
                32'h208, 32'h20C, 32'h210, 32'h214};
      // 4-beat linear write
      for (int k = 0; k < 16; k++) begin
         a[k] = 32'h200 + 32'(4 * k);
         d[k] = 32'(k);
      end
      bus_burst(4, a, d, 1'b1, BTE_LINEAR, acks, errs, rd, lat, after);
      total++;
      if (acks[3:0] !== 4'hf || errs[3:0] !== 4'h0 || lat != 1
          || after !== 1'b0) begin
         bad++;
         $display("FAIL burst_wr: acks=%b errs=%b lat=%0d after=%b, want 1111/0000/1/0",
                  acks[3:0], errs[3:0], lat, after);
      end
      // 4-beat linear read
      for (int k = 0; k < 4; k++)
         sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'(k)});
      bus_burst(4, a, d, 1'b0, BTE_LINEAR, acks, errs, rd, lat, after);
      for (int k = 0; k < 4; k++) begin
         e = sbq.pop_front();
         total++;
         if (acks[k] !== 1'b1 || rd[k] !== e.dat) begin
            bad++;
            $display("FAIL burst_rd beat %0d: ack=%b dat=%h, want ack=1 dat=%h",
                     k, acks[k], rd[k], e.dat);
         end
      end
      total++;
      if (after !== 1'b0) begin
         bad++;
         $display("FAIL burst_rd_end: ack after EOB=%b, want 0", after);
      end
      // wrap-4 read from 0x208
      for (int k = 0; k < 4; k++) begin
         a[k] = wrap4[k];
         sbq.push_back('{err: 1'b0, chk: 1'b1, dat: (wrap4[k] - 32'h200) >> 2});
      end
      bus_burst(4, a, d, 1'b0, BTE_WRAP4, acks, errs, rd, lat, after);
      for (int k = 0; k < 4; k++) begin
         e = sbq.pop_front();
         total++;
         if (acks[k] !== 1'b1 || rd[k] !== e.dat) begin
            bad++;
            $display("FAIL wrap4 beat %0d: ack=%b dat=%h, want ack=1 dat=%h",
                     k, acks[k], rd[k], e.dat);
         end
      end
      // 8-beat linear write then wrap-8 read from 0x218
      for (int k = 0; k < 8; k++) begin
         a[k] = 32'h200 + 32'(4 * k);
         d[k] = 32'(k);
      end
      bus_burst(8, a, d, 1'b1, BTE_LINEAR, acks, errs, rd, lat, after);
      for (int k = 0; k < 8; k++) begin
         a[k] = wrap8[k];
         sbq.push_back('{err: 1'b0, chk: 1'b1, dat: (wrap8[k] - 32'h200) >> 2});
      end
      bus_burst(8, a, d, 1'b0, BTE_WRAP8, acks, errs, rd, lat, after);
      for (int k = 0; k < 8; k++) begin
         e = sbq.pop_front();
         total++;
         if (acks[k] !== 1'b1 || rd[k] !== e.dat) begin
            bad++;
            $display("FAIL wrap8 beat %0d: ack=%b dat=%h, want ack=1 dat=%h",
                     k, acks[k], rd[k], e.dat);
         end
      end
   endtask

   task automatic test_illegal();
      logic        ack, err, after;
      logic [31:0] rd;
      int          lat;
      logic [31:0] adrs[5];
      logic [31:0] dats[5];
      logic        wes[5];
      exp_t        e;
      adrs = '{32'h8000, 32'h0, 32'h102, 32'h100, 32'h7FFC};
      dats = '{32'hCAFEF00D, 32'h0, 32'h55555555, 32'h0, 32'h5A5AA5A5};
      wes  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      sbq.push_back('{err: 1'b1, chk: 1'b0, dat: 32'h0});
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'h0});
      sbq.push_back('{err: 1'b1, chk: 1'b1, dat: 32'h0});
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hDE22BE44});
      sbq.push_back('{err: 1'b0, chk: 1'b0, dat: 32'h0});
      for (int i = 0; i < 5; i++) begin
         bus_classic(adrs[i], dats[i], 4'hf, wes[i],
                     ack, err, rd, lat, after);
         e = sbq.pop_front();
         total++;
         if (err !== e.err || ack !== ~e.err || after !== 1'b0
             || (e.chk && rd !== e.dat)) begin
            bad++;
            $display("FAIL illegal[%0d] adr=%h: ack=%b err=%b dat=%h after=%b, want err=%b dat=%h",
                     i, adrs[i], ack, err, rd, after, e.err, e.dat);
         end
      end
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'h5A5AA5A5});
      bus_classic(32'h7FFC, 32'h0, 4'h0, 1'b0, ack, err, rd, lat, after);
      e = sbq.pop_front();
      total++;
      if (ack !== 1'b1 || rd !== e.dat) begin
         bad++;
         $display("FAIL top_word: ack=%b dat=%h, want ack=1 dat=%h",
                  ack, rd, e.dat);
      end
      total++;
      if (rty_seen !== 1'b0) begin
         bad++;
         $display("FAIL rty: seen=%b, want 0", rty_seen);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic        ack, err, after;
      logic [31:0] rd;
      int          lat;
      exp_t        e;
      for (int k = 0; k < 4; k++)
         bus_classic(32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 4'hf, 1'b1,
                     ack, err, rd, lat, after);
      drv(32'h300, 32'h11, 4'hf, 1'b1, CTI_INC, BTE_LINEAR);
      lat = 0;
      while (lat < 8) begin
         @(posedge wb_clk_i);
         lat++;
         #1;
         if (wb_ack_o) break;
      end
      @(posedge wb_clk_i);
      #1;
      drv(32'h304, 32'h22, 4'hf, 1'b1, CTI_INC, BTE_LINEAR);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      total++;
      if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0)
      begin
         bad++;
         $display("FAIL rst_burst: ack=%b err=%b dat=%h, want 0/0/0",
                  wb_ack_o, wb_err_o, wb_dat_o);
      end
      wb_rst_i = 1'b0;
      idle_bus();
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'h11});
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hA1});
      sbq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hA2});
      for (int k = 0; k < 3; k++) begin
         bus_classic(32'h300 + 32'(4 * k), 32'h0, 4'h0, 1'b0,
                     ack, err, rd, lat, after);
         e = sbq.pop_front();
         total++;
         if (ack !== 1'b1 || rd !== e.dat) begin
            bad++;
            $display("FAIL rst_burst_mem[%0d]: ack=%b dat=%h, want ack=1 dat=%h",
                     k, ack, rd, e.dat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_classic();
      test_byte_lanes();
      test_bursts();
      test_illegal();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
